subtractor_seq: RTL and testbench
=================================

Name: subtractor_seq

Overview:
- Multi-cycle, chunked two's-complement subtractor: Diff = A - B - Bin (mod 2^WIDTH), plus borrow-out and signed overflow.
- It is the inverse-direction companion of the n-bit ripple adder in the shared arithmetic library.
- It processes CHUNK bits per cycle through a registered borrow chain, trading latency for a short critical path.
- Used by the FP exponent-difference and mantissa-alignment paths behind a valid/ready handshake.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CHUNK, 8, bits subtracted per cycle. Must divide WIDTH evenly; elaboration error otherwise.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands A, B, Bin presented.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- Bin  input  1  borrow-in.
- out_valid  output  1  result held valid.
- out_ready  input  1  consumer takes result.
- Diff  output  WIDTH  A - B - Bin, modulo 2^WIDTH.
- Bout  output  1  unsigned borrow-out; 1 iff A < B + Bin (unsigned).
- Ovf  output  1  signed overflow of A - B - Bin.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, Diff=0, Bout=0, Ovf=0, chunk index=0, borrow register=0.
- Reset mid-operation (RUN or DONE) abandons the operation. The cycle after rst, all outputs are at reset values and no result is emitted.
- FSM has three states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid && in_ready, latch A, B; set borrow register=Bin, idx=0; go to RUN.
  - RUN: in_ready=0. Each cycle, compute chunk idx (bits [idx*CHUNK +: CHUNK]) as A_chunk - B_chunk - borrow. Write it into the Diff register slice and update the borrow register. After chunk N-1 (N = WIDTH/CHUNK): set Bout, Ovf, out_valid=1; go to DONE.
  - DONE: out_valid=1. Diff, Bout and Ovf are held stable while out_ready=0. On out_ready=1: out_valid=0, go to IDLE.
- in_ready = (state==IDLE), combinational from state. There is no accept in the same cycle as a DONE handoff.
- Latency: out_valid rises exactly N cycles after the accepting edge (N=4 at defaults). Throughput: one operation per N+2 cycles with out_ready held high.
- Operands are captured on accept. Changes on A/B/Bin during RUN or DONE have no effect.
- Arithmetic per chunk: {borrow_next, d} = A_chunk - B_chunk - borrow, evaluated at CHUNK+1 bits. Equivalently borrow_next = NOT carry-out of A_chunk + ~B_chunk + ~borrow.
- Bout = final borrow register value.
- Ovf = (A[WIDTH-1] != B[WIDTH-1]) && (Diff[WIDTH-1] != A[WIDTH-1]). This is valid including the Bin=1 case.
- Diff slices not yet computed during RUN are don't-care internally. Diff is only defined while out_valid=1.
- Degenerate case CHUNK==WIDTH: N=1, so out_valid rises 1 cycle after accept.

Decomposition:
- Shared header arith_defs.vh holds:
  - FSM state encodings: S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
  - The chunk-count helper macro.
- One sub-module, sub_chunk, #(CHUNK): a combinational CHUNK-bit borrow-ripple subtractor. Inputs A, B, Bin; outputs Diff, Bout. It is instantiated once and time-multiplexed by the FSM.

Test Plan:
- Basic: A=5, B=3, Bin=0 -> Diff=0x00000002, Bout=0, Ovf=0; out_valid exactly 4 cycles after accept.
- Unsigned underflow: A=0, B=1, Bin=0 -> Diff=0xFFFFFFFF, Bout=1, Ovf=0.
- Signed overflow: A=0x80000000, B=1, Bin=0 -> Diff=0x7FFFFFFF, Bout=0, Ovf=1. Also A=0x7FFFFFFF, B=0xFFFFFFFF -> Diff=0x80000000, Bout=1, Ovf=1.
- Borrow-in across all chunks: A=B=0x12345678, Bin=1 -> Diff=0xFFFFFFFF, Bout=1, Ovf=0. Also A=0x00000100, B=0, Bin=1 -> Diff=0x000000FF (borrow crosses chunk 0 to chunk 1).
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> Diff/Bout/Ovf stable, in_ready=0, out_valid=1. Raise out_ready -> in_ready=1 the next cycle; a back-to-back op is then accepted and completes correctly. Operand changes during RUN are ignored.
- Reset mid-RUN: assert rst 2 cycles after accept -> next cycle out_valid=0, in_ready=1, Diff=0. A subsequent op A=10, B=4 -> Diff=6.

Source files
------------

// File: rtl/subtractor_seq_pkg.sv
// ---------------------------------------------------------------------------
// subtractor_seq_pkg
//   Shared definitions for the chunked sequential subtractor:
//   - FSM state encodings (kept as plain 2-bit constants so older code that
//     compares against raw encodings keeps working)
//   - chunk-count helper used to size the chunk index
// ---------------------------------------------------------------------------
package subtractor_seq_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Number of CHUNK-bit slices in a WIDTH-bit operand.
  function automatic int num_chunks(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/subtractor_seq_sub_chunk.sv
// ---------------------------------------------------------------------------
// sub_chunk
//   Combinational CHUNK-bit borrow-ripple subtractor:
//   {Bout, Diff} = A - B - Bin.
//   Ports:
//     A    [CHUNK-1:0]  minuend slice
//     B    [CHUNK-1:0]  subtrahend slice
//     Bin               borrow into bit 0
//     Diff [CHUNK-1:0]  difference slice
//     Bout              borrow out of the top bit
// ---------------------------------------------------------------------------
module sub_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] A,
  input  logic [CHUNK-1:0] B,
  input  logic             Bin,
  output logic [CHUNK-1:0] Diff,
  output logic             Bout
);

  // Bit-serial borrow ripple across the slice.
  always_comb begin
    logic bw;
    bw   = Bin;
    Diff = '0;
    for (int i = 0; i < CHUNK; i++) begin
      Diff[i] = A[i] ^ B[i] ^ bw;
      // Borrow when a 0 sees a 1 below it, or equal bits pass the borrow on.
      bw = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & bw);
    end
    Bout = bw;
  end

endmodule

// File: rtl/subtractor_seq.sv
// ---------------------------------------------------------------------------
// subtractor_seq
//   Multi-cycle chunked two's-complement subtractor:
//   Diff = A - B - Bin (mod 2^WIDTH), with unsigned borrow-out and signed
//   overflow. One CHUNK-bit slice is processed per cycle through a single
//   time-multiplexed sub_chunk and a registered borrow.
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     in_valid/in_ready operand handshake (in_ready only in IDLE)
//     A, B, Bin         minuend, subtrahend, borrow-in (captured on accept)
//     out_valid/out_ready result handshake
//     Diff, Bout, Ovf   result, unsigned borrow-out, signed overflow
// ---------------------------------------------------------------------------
module subtractor_seq
  import subtractor_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Ovf
);

  localparam int N     = num_chunks(WIDTH, CHUNK);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("subtractor_seq: CHUNK must divide WIDTH evenly");
  end

  logic [1:0]       state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             borrow;
  logic [IDX_W-1:0] idx;

  int               base;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] d_chunk;
  logic             bout_chunk;

  assign in_ready = (state == S_IDLE);

  // Select the operand slices for the chunk currently being processed.
  always_comb begin
    base    = int'(idx) * CHUNK;
    a_chunk = a_reg[base +: CHUNK];
    b_chunk = b_reg[base +: CHUNK];
  end

  sub_chunk #(.CHUNK(CHUNK)) u_sub_chunk (
    .A    (a_chunk),
    .B    (b_chunk),
    .Bin  (borrow),
    .Diff (d_chunk),
    .Bout (bout_chunk)
  );

  // Handshake FSM, operand capture and per-chunk result accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      borrow    <= 1'b0;
      idx       <= '0;
      out_valid <= 1'b0;
      Diff      <= '0;
      Bout      <= 1'b0;
      Ovf       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_reg  <= A;
            b_reg  <= B;
            borrow <= Bin;
            idx    <= '0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          Diff[base +: CHUNK] <= d_chunk;
          borrow              <= bout_chunk;
          if (idx == LAST_IDX) begin
            Bout      <= bout_chunk;
            // d_chunk's MSB is the result's sign bit on the last chunk.
            Ovf       <= (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]) &
                         (d_chunk[CHUNK-1] ^ a_reg[WIDTH-1]);
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_subtractor_seq.sv
// ---------------------------------------------------------------------------
// tb_subtractor_seq
//   Directed self-checking bench for subtractor_seq at WIDTH=32, CHUNK=8.
// ---------------------------------------------------------------------------
module tb_subtractor_seq;

  localparam int W = 32;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Diff;
  logic         Bout;
  logic         Ovf;

  int vectors = 0;
  int miscompares = 0;

  subtractor_seq #(.WIDTH(32), .CHUNK(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Diff      (Diff),
    .Bout      (Bout),
    .Ovf       (Ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept an operation, check exact latency, result, then optionally hand off.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bin, input logic [W-1:0] exp_d, input logic exp_bo,
                        input logic exp_ov, input logic handoff);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    check({tag, "_in_ready"}, W'(in_ready), W'(1));
    A = a; B = b; Bin = bin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (k > 1) tick();
      if (k < N) check({tag, "_lat_low"}, W'(out_valid), W'(0));
    end
    tick();
    check({tag, "_lat_high"}, W'(out_valid), W'(1));
    check({tag, "_Diff"}, Diff, exp_d);
    check({tag, "_Bout"}, W'(Bout), W'(exp_bo));
    check({tag, "_Ovf"},  W'(Ovf),  W'(exp_ov));
    check({tag, "_busy"}, W'(in_ready), W'(0));
    if (handoff) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_done_low"}, W'(out_valid), W'(0));
      check({tag, "_idle"}, W'(in_ready), W'(1));
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; Bin = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready",  W'(in_ready),  W'(1));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_Diff", Diff, 32'h0000_0000);
    check("rst_Bout", W'(Bout), W'(0));
    check("rst_Ovf",  W'(Ovf),  W'(0));

    run_op("basic",  32'd5,         32'd3,         1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b1);
    run_op("uflow",  32'd0,         32'd1,         1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
    run_op("sovf_a", 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
    run_op("sovf_b", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b1);
    run_op("bin_all", 32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
    run_op("bin_x01", 32'h0000_0100, 32'h0000_0000, 1'b1, 32'h0000_00FF, 1'b0, 1'b0, 1'b1);

    // Backpressure: operands change mid-RUN, result must still be 0x10000-1.
    A = 32'h0001_0000; B = 32'h0000_0001; Bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    A = 32'hFFFF_FFFF; B = 32'h1234_5678; Bin = 1'b1;
    tick();
    tick();
    tick();
    tick();
    check("bp_valid", W'(out_valid), W'(1));
    for (int c = 0; c < 3; c++) begin
      tick();
      check("bp_hold_Diff",  Diff, 32'h0000_FFFF);
      check("bp_hold_Bout",  W'(Bout), W'(0));
      check("bp_hold_Ovf",   W'(Ovf),  W'(0));
      check("bp_hold_valid", W'(out_valid), W'(1));
      check("bp_hold_ready", W'(in_ready),  W'(0));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_ready", W'(in_ready), W'(1));
    check("bp_release_valid", W'(out_valid), W'(0));
    run_op("b2b", 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 32'h4B4B_4B4A, 1'b0, 1'b1, 1'b1);

    // Reset two cycles after accept abandons the operation.
    A = 32'hDEAD_BEEF; B = 32'h0000_0001; Bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_out_valid", W'(out_valid), W'(0));
    check("mrst_in_ready",  W'(in_ready),  W'(1));
    check("mrst_Diff", Diff, 32'h0000_0000);
    tick();
    tick();
    check("mrst_no_result", W'(out_valid), W'(0));
    run_op("post_rst", 32'd10, 32'd4, 1'b0, 32'h0000_0006, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
